// File: rtl/icarus_work_rx.sv
// Serial work receiver: deserialises 8N1 UART bytes into a fixed-length
// getwork frame and strobes the completed frame out to the hashing core.
// A partial frame is dropped after a long idle gap, so a host that
// restarts mid-frame always lines back up on the next frame.
module icarus_work_rx #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200,
    parameter int NUM_BYTES          = 84,
    parameter int TIMEOUT_BITS       = 40
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   RxD,
    output logic [NUM_BYTES*8-1:0] work_data,
    output logic                   rx_done,
    output logic                   frame_error,
    output logic [6:0]             byte_count
);

    localparam int BIT_DIV        = comm_clk_frequency / baud_rate;
    localparam int FRAME_W        = NUM_BYTES * 8;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_DIV;
    localparam int DIV_W          = $clog2(BIT_DIV);
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]       BC_LAST  = 7'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rxd_p0;
    logic                rxd_p1;
    logic                rxd_p2;
    logic                fall;
    logic [DIV_W-1:0]    div;
    logic [2:0]          bit_cnt;
    logic [7:0]          rx_byte;
    logic [FRAME_W-1:0]  shreg;
    logic [FRAME_W-1:0]  shifted;
    logic [TO_W-1:0]     idle_cnt;
    logic                div_clr;
    logic                sample_bit;
    logic                byte_ok;
    logic                byte_bad;
    logic                timeout;

    // RxD is asynchronous: two flops for metastability, a third to spot the falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RxD;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    assign fall    = rxd_p2 & ~rxd_p1;
    assign shifted = {shreg[FRAME_W-9:0], rx_byte};
    assign timeout = (state == S_IDLE) && (byte_count != 7'd0) && (idle_cnt == TO_LAST);

    // Bit FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit FSM next state and per-cycle sampling controls.
    always_comb begin
        state_nxt  = state;
        div_clr    = 1'b0;
        sample_bit = 1'b0;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt = S_START;
                    div_clr   = 1'b1;
                end
            end
            S_START: begin
                // Re-check the start bit at its middle; a high line means a glitch.
                if (div == DIV_HALF) begin
                    div_clr = 1'b1;
                    if (!rxd_p1) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (div == DIV_LAST) begin
                    sample_bit = 1'b1;
                    div_clr    = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so the next start edge is never missed.
                if (div == DIV_LAST) begin
                    div_clr = 1'b1;
                    if (rxd_p1) begin
                        byte_ok   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        byte_bad  = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A low stop bit may be a break; wait for idle before hunting for a start edge.
                if (rxd_p1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit-period divider, data bit counter and LSB-first byte shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            bit_cnt <= 3'd0;
            rx_byte <= 8'd0;
        end else begin
            if (div_clr) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (state == S_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sample_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sample_bit) begin
                rx_byte <= {rxd_p1, rx_byte[7:1]};
            end
        end
    end

    // Idle gap counter: runs only while a partial frame sits in IDLE, so any byte activity restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if ((state != S_IDLE) || (byte_count == 7'd0) || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Frame assembly, completed-frame publish and the two status strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg       <= '0;
            work_data   <= '0;
            byte_count  <= 7'd0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            frame_error <= byte_bad;
            if (timeout) begin
                byte_count <= 7'd0;
                shreg      <= '0;
            end else if (byte_ok) begin
                shreg <= shifted;
                if (byte_count == BC_LAST) begin
                    work_data  <= shifted;
                    byte_count <= 7'd0;
                    rx_done    <= 1'b1;
                end else begin
                    byte_count <= byte_count + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_icarus_work_rx.sv
// Directed bench for icarus_work_rx at 8 clocks per bit.
`timescale 1ns/1ps
module tb_icarus_work_rx;

    localparam int BIT_DIV = 8;
    localparam int FRAME_W = 672;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               RxD = 1'b1;
    logic [FRAME_W-1:0] work_data;
    logic               rx_done;
    logic               frame_error;
    logic [6:0]         byte_count;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    int     done_cnt = 0;
    int     ferr_cnt = 0;
    longint last_done_cyc = 0;
    longint prev_done_cyc = 0;

    always #5 clk = ~clk;

    icarus_work_rx #(
        .comm_clk_frequency(1_000_000),
        .baud_rate(115_200),
        .NUM_BYTES(84),
        .TIMEOUT_BITS(40)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .RxD(RxD),
        .work_data(work_data),
        .rx_done(rx_done),
        .frame_error(frame_error),
        .byte_count(byte_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= last_done_cyc;
            last_done_cyc <= cyc;
        end
        if (frame_error === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int kind, input int i);
        logic [7:0] b;
        case (kind)
            0:       b = 8'(i);
            1:       b = 8'hFF;
            2:       b = 8'(i) ^ 8'h5A;
            3:       b = 8'(255 - i);
            default: b = 8'(i * 7 + 3);
        endcase
        return b;
    endfunction

    function automatic logic [FRAME_W-1:0] fexp(input int kind);
        logic [FRAME_W-1:0] v;
        v = '0;
        for (int i = 0; i < 84; i++) begin
            v[FRAME_W-1-8*i -: 8] = fbyte(kind, i);
        end
        return v;
    endfunction

    // Called at a negedge; returns at a negedge with the line idle high.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        RxD = 1'b0;
        repeat (BIT_DIV) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            RxD = b[k];
            repeat (BIT_DIV) @(negedge clk);
        end
        RxD = stop;
        repeat (BIT_DIV) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic send_bytes(input int kind, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(fbyte(kind, i), 1'b1);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_DIV) @(negedge clk);
    endtask

    initial begin
        int     d0;
        int     f0;
        longint start_cyc;
        longint lat;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_work_data", work_data, '0);
        chk("reset_rx_done", FRAME_W'(rx_done), '0);
        chk("reset_frame_error", FRAME_W'(frame_error), '0);
        chk("reset_byte_count", FRAME_W'(byte_count), '0);
        reset_n = 1'b1;
        idle_bits(2);

        // Baseline frame 0x00..0x53 back-to-back.
        d0 = done_cnt;
        start_cyc = cyc;
        send_bytes(0, 0, 83);
        repeat (4) @(negedge clk);
        chk("base_done_count", FRAME_W'(done_cnt - d0), FRAME_W'(1));
        lat = last_done_cyc - start_cyc;
        chk("base_latency_in_range", FRAME_W'((lat >= 6640) && (lat <= 6760)), FRAME_W'(1));
        chk("base_first_byte", FRAME_W'(work_data[671:664]), FRAME_W'(8'h00));
        chk("base_last_byte", FRAME_W'(work_data[7:0]), FRAME_W'(8'h53));
        chk("base_frame", work_data, fexp(0));
        chk("base_byte_count", FRAME_W'(byte_count), '0);
        chk("base_no_ferr", FRAME_W'(ferr_cnt), '0);

        // Two-cycle glitch on the idle line.
        d0 = done_cnt;
        f0 = ferr_cnt;
        RxD = 1'b0;
        repeat (2) @(negedge clk);
        RxD = 1'b1;
        idle_bits(3);
        chk("glitch_byte_count", FRAME_W'(byte_count), '0);
        chk("glitch_no_ferr", FRAME_W'(ferr_cnt - f0), '0);
        chk("glitch_no_done", FRAME_W'(done_cnt - d0), '0);

        // Bad stop bit, then a valid byte, then timeout clears it.
        f0 = ferr_cnt;
        send_byte(8'hA5, 1'b0);
        idle_bits(2);
        chk("badstop_ferr_once", FRAME_W'(ferr_cnt - f0), FRAME_W'(1));
        chk("badstop_byte_count", FRAME_W'(byte_count), '0);
        send_byte(8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        chk("after_badstop_accept", FRAME_W'(byte_count), FRAME_W'(1));
        idle_bits(41);
        chk("single_byte_timeout", FRAME_W'(byte_count), '0);

        // Aborted frame of 40 bytes, then a full 0xFF frame.
        d0 = done_cnt;
        send_bytes(0, 0, 39);
        repeat (2) @(negedge clk);
        chk("abort_partial_count", FRAME_W'(byte_count), FRAME_W'(40));
        idle_bits(30);
        chk("abort_before_timeout", FRAME_W'(byte_count), FRAME_W'(40));
        idle_bits(11);
        chk("abort_after_timeout", FRAME_W'(byte_count), '0);
        chk("abort_work_data_kept", work_data, fexp(0));
        chk("abort_no_done", FRAME_W'(done_cnt - d0), '0);
        send_bytes(1, 0, 83);
        repeat (4) @(negedge clk);
        chk("ones_done_count", FRAME_W'(done_cnt - d0), FRAME_W'(1));
        chk("ones_frame", work_data, {FRAME_W{1'b1}});
        chk("ones_byte_count", FRAME_W'(byte_count), '0);

        // Reset during byte 30.
        send_bytes(4, 0, 28);
        RxD = 1'b0;
        repeat (BIT_DIV) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * BIT_DIV) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_work_data", work_data, '0);
        chk("midreset_byte_count", FRAME_W'(byte_count), '0);
        chk("midreset_rx_done", FRAME_W'(rx_done), '0);
        chk("midreset_frame_error", FRAME_W'(frame_error), '0);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        idle_bits(2);
        d0 = done_cnt;
        send_bytes(4, 0, 83);
        repeat (4) @(negedge clk);
        chk("postreset_done_count", FRAME_W'(done_cnt - d0), FRAME_W'(1));
        chk("postreset_frame", work_data, fexp(4));

        // Two frames with no gap.
        d0 = done_cnt;
        send_bytes(2, 0, 83);
        send_bytes(3, 0, 39);
        chk("b2b_first_done", FRAME_W'(done_cnt - d0), FRAME_W'(1));
        chk("b2b_frame1_held", work_data, fexp(2));
        chk("b2b_mid_count", FRAME_W'(byte_count), FRAME_W'(40));
        send_bytes(3, 40, 83);
        repeat (4) @(negedge clk);
        chk("b2b_second_done", FRAME_W'(done_cnt - d0), FRAME_W'(2));
        chk("b2b_spacing", FRAME_W'(last_done_cyc - prev_done_cyc), FRAME_W'(84 * 80));
        chk("b2b_frame2", work_data, fexp(3));
        chk("b2b_no_ferr", FRAME_W'(ferr_cnt), FRAME_W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
